// File: rtl/vp_pkg.sv
// vp_pkg: shared types and constants for the vector processor front end.
package vp_pkg;
  localparam int INSTR_W = 13;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
  // Opcode field values; the sequencer never decodes these, only benches use them.
  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_STORE = 2'd1;
  localparam logic [1:0] OP_ADD   = 2'd2;
  localparam logic [1:0] OP_MUL   = 2'd3;
endpackage

// File: rtl/vp_prog_ram.sv
// vp_prog_ram: program buffer with synchronous gated write and asynchronous read.
module vp_prog_ram #(
  parameter int INSTR_W = 13,
  parameter int DEPTH   = 16,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic               we_gate_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);
  logic [INSTR_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i && we_gate_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/vp_instruction_sequencer.sv
// vp_instruction_sequencer: issues a loaded program of opaque instructions in order
// over a valid/ready handshake, then reports done.
module vp_instruction_sequencer
  import vp_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_wdata,
  input  logic [AW:0]        prog_len,
  input  logic               start,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [AW-1:0]      pc,
  output logic               busy,
  output logic               done,
  output logic               prog_err
);
  seq_state_t         state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d, rdata;
  logic [AW-1:0]      pc_q, pc_d, raddr;
  logic [AW:0]        rem_q, rem_d, len_sat;
  logic               err_q, err_d;
  logic               in_run, fire, launch, load, step;
  assign in_run  = state_q == RUN;
  assign fire    = in_run && instr_ready;
  assign launch  = start && !in_run;
  assign load    = launch && prog_len != '0;
  assign step    = fire && rem_q > (AW+1)'(1);
  assign len_sat = prog_len > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : prog_len;
  // Outside RUN the only read needed is entry 0 for a launch.
  assign raddr   = in_run ? pc_q + AW'(1) : '0;
  vp_prog_ram #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk       (clk),
    .we_i      (prog_we),
    .we_gate_i (!in_run),
    .waddr_i   (prog_addr),
    .wdata_i   (prog_wdata),
    .raddr_i   (raddr),
    .rdata_o   (rdata)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = in_run ? ((fire && !step) ? DONE : RUN)
                     : (start ? (prog_len == '0 ? DONE : RUN) : state_q);
  end
  always_comb begin
    instr_d = (load || step) ? rdata : instr_q;
    pc_d    = load ? '0 : (step ? pc_q + AW'(1) : pc_q);
    rem_d   = load ? len_sat : (step ? rem_q - (AW+1)'(1) : (fire ? '0 : rem_q));
    err_d   = (prog_we && in_run) ? 1'b1 : (launch ? 1'b0 : err_q);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  assign instr_out   = instr_q;
  assign instr_valid = in_run;
  assign pc          = pc_q;
  assign busy        = in_run;
  assign done        = state_q == DONE;
  assign prog_err    = err_q;
endmodule

// File: tb/tb_vp_instruction_sequencer.sv
// tb_vp_instruction_sequencer: directed scoreboard bench for the instruction sequencer.
module tb_vp_instruction_sequencer;
  import vp_pkg::*;
  typedef struct packed {logic [12:0] instr; logic [3:0] pc;} exp_t;
  logic        clk = 0, reset = 0, prog_we = 0, start = 0, instr_ready = 0;
  logic [3:0]  prog_addr = '0;
  logic [12:0] prog_wdata = '0;
  logic [4:0]  prog_len = '0;
  logic [12:0] instr_out;
  logic [3:0]  pc;
  logic        instr_valid, busy, done, prog_err;
  logic [12:0] model [16];
  exp_t        sb [$];
  int          tests = 0, fails = 0, acc = 0;

  vp_instruction_sequencer dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .prog_len(prog_len), .start(start),
    .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .busy(busy), .done(done), .prog_err(prog_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [3:0] a, input logic [12:0] d);
    prog_we = 1; prog_addr = a; prog_wdata = d;
    model[a] = d;
    @(negedge clk);
    prog_we = 0;
  endtask

  task automatic start_run(input int len);
    int n = len > 16 ? 16 : len;
    prog_len = 5'(len); start = 1;
    for (int i = 0; i < n; i++) sb.push_back({model[i], 4'(i)});
    @(negedge clk);
    start = 0;
    if (len == 0) begin
      check("len0_done", done, 1);
      check("len0_valid", instr_valid, 0);
    end else begin
      check("start_valid", instr_valid, 1);
      check("start_pc", pc, 0);
      check("start_busy", busy, 1);
      check("start_err_clr", prog_err, 0);
    end
  endtask

  task automatic drain(input logic [31:0] pat, input int plen, input bit inj,
                       input int max_acc, output int n_acc);
    int cyc = 0;
    bit hold = 0;
    logic [12:0] po;
    logic [3:0] ppc;
    exp_t e;
    n_acc = 0;
    while (instr_valid && n_acc < max_acc && cyc < 200) begin
      if (hold) begin
        check("hold_instr", instr_out, po);
        check("hold_pc", pc, ppc);
      end
      instr_ready = pat[cyc % plen];
      prog_we = inj && cyc == 1; prog_addr = 4'd2; prog_wdata = 13'h1FFF;
      hold = !instr_ready; po = instr_out; ppc = pc;
      if (instr_ready) begin
        if (sb.size() == 0) check("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          check("instr", instr_out, e.instr);
          check("pc", pc, e.pc);
        end
        n_acc++;
      end
      cyc++;
      @(negedge clk);
    end
    instr_ready = 0; prog_we = 0;
    check("cycle_budget", cyc < 200, 1);
  endtask

  task automatic check_done(input logic [3:0] last_pc, input logic [12:0] last_instr);
    check("done", done, 1);
    check("done_valid", instr_valid, 0);
    check("done_busy", busy, 0);
    check("sb_empty", sb.size(), 0);
    check("end_pc", pc, last_pc);
    check("end_instr", instr_out, last_instr);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_instr", instr_out, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", prog_err, 0);
    reset = 1;
    @(negedge clk);
    write(0, 13'h1000); write(1, 13'h1800); write(2, 13'h0001); write(3, 13'h0208);
    for (int i = 4; i < 16; i++) write(4'(i), 13'h0100 + 13'(i * 7));

    // back-to-back issue with ready held high
    start_run(4);
    drain(32'hFFFFFFFF, 1, 0, 100, acc);
    check("run1_count", acc, 4);
    check_done(3, 13'h0208);
    @(negedge clk);
    check("done_sticky", done, 1);

    // ready toggled 1,0,0,1,1,0,1
    start_run(4);
    check("done_drop", done, 0);
    drain(32'b1011001, 7, 0, 100, acc);
    check("run2_count", acc, 4);
    check_done(3, 13'h0208);

    // write attempt during RUN is dropped and flagged
    start_run(4);
    drain(32'b10, 2, 1, 100, acc);
    check("err_count", acc, 4);
    check("err_set", prog_err, 1);
    start_run(4);
    drain(32'hFFFFFFFF, 1, 0, 100, acc);
    check("rerun_count", acc, 4);
    check_done(3, 13'h0208);

    // asynchronous reset after two acceptances
    start_run(4);
    drain(32'hFFFFFFFF, 1, 0, 2, acc);
    check("pre_rst_pc", pc, 2);
    #2 reset = 0;
    #1;
    check("mid_rst_instr", instr_out, 0);
    check("mid_rst_valid", instr_valid, 0);
    check("mid_rst_pc", pc, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    sb.delete();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("post_rst_valid", instr_valid, 0);
    check("post_rst_done", done, 0);

    // zero-length program goes straight to DONE
    start_run(0);
    repeat (3) begin
      @(negedge clk);
      check("len0_quiet", instr_valid, 0);
    end
    start_run(4);
    drain(32'hFFFFFFFF, 1, 0, 100, acc);
    check("after_rst_count", acc, 4);
    check_done(3, 13'h0208);

    // oversize length saturates to DEPTH
    start_run(21);
    drain(32'hFFFFFFFF, 1, 0, 100, acc);
    check("sat_count", acc, 16);
    check_done(15, model[15]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vp_instruction_sequencer.md
Name: vp_instruction_sequencer

Overview:
- Upstream stage of Vector_Processor. Holds a small program buffer of 13-bit vector instructions and issues them in order under a valid/ready handshake.
- Replaces hand-driven instruction stimulus: a program is loaded, `start` is pulsed, and the block streams `prog_len` instructions, then reports done.
- Instruction encoding is opaque to this block; it never decodes opcodes.

Parameters:
- INSTR_W, 13, instruction width (matches Vector_Processor instruction port)
- DEPTH, 16, program buffer entries (power of two, ≥2)
- AW, $clog2(DEPTH), program address width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- prog_we  in  1  program buffer write strobe
- prog_addr  in  AW  program write address
- prog_wdata  in  INSTR_W  instruction to store
- prog_len  in  AW+1  number of instructions to issue, sampled on start
- start  in  1  single-cycle start pulse
- instr_out  out  INSTR_W  instruction to Vector_Processor
- instr_valid  out  1  instr_out holds an unissued instruction
- instr_ready  in  1  consumer accepts instr_out this cycle
- pc  out  AW  index of instruction currently presented
- busy  out  1  high in RUN
- done  out  1  high in DONE until next start
- prog_err  out  1  sticky; write attempted during RUN

Behaviour:
- Reset (reset=0, async) forces the following: state IDLE; instr_out=0; instr_valid=0; pc=0; busy=0; done=0; prog_err=0; remaining-count=0. Buffer contents are not reset.
- Buffer writes: in IDLE/DONE, prog_we writes prog_wdata to buf[prog_addr] at the clock edge. In RUN the write is dropped and prog_err is set; it is cleared only by reset or start.
- States:
  - IDLE: outputs quiet. start with prog_len≠0 → RUN: instr_out←buf[0], instr_valid←1, pc←0, remaining←prog_len, prog_err←0. start with prog_len=0 → DONE directly, instr_valid stays 0.
  - RUN: busy=1; instr_valid=1 continuously.
    - Handshake (valid&ready) with remaining>1: pc←pc+1, instr_out←buf[pc+1] on the same edge, remaining−1. This gives back-to-back issue at one instruction per cycle.
    - Handshake with remaining=1: instr_valid←0 and → DONE. instr_out holds its last value.
    - ready low: instr_out, pc and remaining hold. Output must be stable while valid and not ready.
    - start in RUN is ignored.
  - DONE: done=1, busy=0, instr_valid=0. Same start rule as IDLE; done drops on the edge that leaves DONE.
- Latency: start at edge N → instr_valid=1 after edge N; first acceptance possible at edge N+1.
- prog_len > DEPTH is saturated to DEPTH. pc never wraps within a run.
- A buffer write in the same cycle as start (IDLE/DONE) is committed first for addresses ≥1. instr_out for index 0 uses the pre-write buf[0] contents; this is a documented restriction.
- Reset asserted mid-run aborts immediately with no partial handshake; it behaves as plain reset.
- All outputs are registered except nothing; no combinational path from instr_ready to any output.

Decomposition:
- Shared package vp_pkg:
  - INSTR_W=13
  - 3-state enum seq_state_t (IDLE, RUN, DONE)
  - opcode field constants (LOAD, STORE, ADD, MUL) for benches only
- One sub-module, vp_prog_ram: DEPTH×INSTR_W synchronous-write, asynchronous-read array with a write-enable gate input.
- FSM and counters stay in the top.

Test Plan:
- Reset then load buf[0..3]={13'h1000,13'h1800,13'h0001,13'h0208}, prog_len=4, start, ready tied 1 → instr_out sequence 1000,1800,0001,0208 on four consecutive cycles; pc 0..3; then done=1, instr_valid=0.
- Same program with ready toggled 1,0,0,1,1,0,1 → each instruction accepted exactly once, in order; instr_out/pc stable during every ready=0 cycle; done after the 4th acceptance.
- start with prog_len=0 → DONE next cycle; instr_valid never asserts.
- prog_we during RUN to addr 2 with 13'h1FFF → prog_err=1, buf[2] unchanged (re-run issues original value); next start clears prog_err.
- Assert reset low mid-run after two acceptances → all outputs zero asynchronously; after release, state IDLE and a new start issues from pc=0.
- prog_len=DEPTH+5 with DEPTH=16 → exactly 16 instructions issued, pc ends at 15, no wrap.
